// File: rtl/stopwatch_up_if.sv
// stopwatch_up_if: command and display bundle between a controller and the MM:SS stopwatch
// Signals:
//   start, stop, clear  level commands sampled on posedge (priority clear > stop > start)
//   lap                 1-cycle pulse toggling the display freeze
//   out_second_unit/out_second_tens/out_minute_unit/out_minute_tens  displayed BCD digits
//   running, lap_active, overflow  status flags
// Modports: master drives commands and reads the display; slave is the stopwatch side.
interface stopwatch_up_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       lap;
    logic [3:0] out_second_unit;
    logic [3:0] out_second_tens;
    logic [3:0] out_minute_unit;
    logic [3:0] out_minute_tens;
    logic       running;
    logic       lap_active;
    logic       overflow;
    modport master (
        output start, stop, clear, lap,
        input  out_second_unit, out_second_tens, out_minute_unit, out_minute_tens,
        input  running, lap_active, overflow
    );
    modport slave (
        input  start, stop, clear, lap,
        output out_second_unit, out_second_tens, out_minute_unit, out_minute_tens,
        output running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_up.sv
// stopwatch_up: BCD MM:SS up-counting stopwatch with pause/resume, lap freeze and 59:59 saturation
// Parameters:
//   TICKS_PER_SEC  clk cycles per counted second (>=1)
// Ports:
//   clk  system clock, all state updates on posedge
//   rst  asynchronous, active-low reset
//   bus  stopwatch_up_if.slave: start/stop/clear/lap in; BCD digits, running, lap_active, overflow out
module stopwatch_up #(
    parameter int TICKS_PER_SEC = 1
) (
    input logic           clk,
    input logic           rst,
    stopwatch_up_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [3:0]    su, st, mu, mt;
    logic [3:0]    nsu, nst, nmu, nmt;
    logic [15:0]   shown;
    logic          running, lap_active, overflow;
    logic          c0, c1, c2, tick, at_max;
    // A stop in the same cycle wins over counting, so the partial second is frozen as-is.
    always_comb begin
        tick   = state == RUN && !bus.stop && presc == PW'(TICKS_PER_SEC - 1);
        c0     = su == 4'd9;
        c1     = c0 && st == 4'd5;
        c2     = c1 && mu == 4'd9;
        nsu    = c0 ? 4'd0 : su + 4'd1;
        nst    = c0 ? (st == 4'd5 ? 4'd0 : st + 4'd1) : st;
        nmu    = c1 ? (mu == 4'd9 ? 4'd0 : mu + 4'd1) : mu;
        nmt    = c2 ? mt + 4'd1 : mt;
        at_max = {nmt, nmu, nst, nsu} == 16'h5959;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bus.clear) begin
            state      <= IDLE;
            presc      <= '0;
            {mt, mu, st, su} <= '0;
            shown      <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (bus.lap && state != IDLE)
                lap_active <= !lap_active;
            // Display tracks the count unless frozen; the toggling lap edge itself reloads it.
            if (!lap_active || bus.lap)
                shown <= {mt, mu, st, su};
            if (tick) begin
                {mt, mu, st, su} <= {nmt, nmu, nst, nsu};
                presc <= '0;
                if (at_max) begin
                    state    <= DONE;
                    running  <= 1'b0;
                    overflow <= 1'b1;
                end
            end else if (state == RUN && !bus.stop) begin
                presc <= presc + PW'(1);
            end else if (state == RUN) begin
                state   <= PAUSED;
                running <= 1'b0;
            end else if (state != DONE && !bus.stop && bus.start) begin
                state   <= RUN;
                running <= 1'b1;
                if (state == IDLE)
                    presc <= '0;
            end
        end
    end
    assign {bus.out_minute_tens, bus.out_minute_unit, bus.out_second_tens, bus.out_second_unit} = shown;
    assign bus.running    = running;
    assign bus.lap_active = lap_active;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_stopwatch_up.sv
// tb_stopwatch_up: randomized and directed check of stopwatch_up (TICKS_PER_SEC 1 and 4) against an elapsed-seconds model
module tb_stopwatch_up;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    stopwatch_up_if b1 ();
    stopwatch_up_if b4 ();
    assign b1.start = start;
    assign b1.stop  = stop;
    assign b1.clear = clear;
    assign b1.lap   = lap;
    assign b4.start = start;
    assign b4.stop  = stop;
    assign b4.clear = clear;
    assign b4.lap   = lap;
    stopwatch_up #(.TICKS_PER_SEC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    stopwatch_up #(.TICKS_PER_SEC(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    // Model: mode 0 idle, 1 run, 2 paused, 3 done; time kept as plain elapsed seconds.
    int m_mode[2], m_sub[2], m_secs[2], m_shown[2];
    bit m_lap[2], m_ovf[2];
    int tps[2] = '{1, 4};
    function automatic logic [15:0] to_bcd(input int s);
        int m = s / 60;
        int x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_sub[i] = 0; m_secs[i] = 0; m_shown[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
        end
    endtask
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int  old_secs = m_secs[i];
            bit  frozen = m_lap[i] && !lap;
            if (clear) begin
                m_mode[i] = 0; m_sub[i] = 0; m_secs[i] = 0; m_shown[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
                continue;
            end
            if (lap && m_mode[i] != 0) m_lap[i] = !m_lap[i];
            if (m_mode[i] == 1) begin
                if (stop) m_mode[i] = 2;
                else if (m_sub[i] == tps[i] - 1) begin
                    m_sub[i] = 0;
                    m_secs[i]++;
                    if (m_secs[i] == 59 * 60 + 59) begin m_mode[i] = 3; m_ovf[i] = 1; end
                end else m_sub[i]++;
            end else if ((m_mode[i] == 0 || m_mode[i] == 2) && start && !stop) begin
                if (m_mode[i] == 0) m_sub[i] = 0;
                m_mode[i] = 1;
            end
            if (!frozen) m_shown[i] = old_secs;
        end
    endtask
    function automatic logic [15:0] disp1();
        return {b1.out_minute_tens, b1.out_minute_unit, b1.out_second_tens, b1.out_second_unit};
    endfunction
    function automatic logic [15:0] disp4();
        return {b4.out_minute_tens, b4.out_minute_unit, b4.out_second_tens, b4.out_second_unit};
    endfunction
    task automatic compare();
        check("disp_t1", 32'(disp1()), 32'(to_bcd(m_shown[0])));
        check("run_t1", 32'(b1.running), 32'(m_mode[0] == 1));
        check("lap_t1", 32'(b1.lap_active), 32'(m_lap[0]));
        check("ovf_t1", 32'(b1.overflow), 32'(m_ovf[0]));
        check("disp_t4", 32'(disp4()), 32'(to_bcd(m_shown[1])));
        check("run_t4", 32'(b4.running), 32'(m_mode[1] == 1));
        check("lap_t4", 32'(b4.lap_active), 32'(m_lap[1]));
        check("ovf_t4", 32'(b4.overflow), 32'(m_ovf[1]));
    endtask
    task automatic cycle(input bit s, input bit p, input bit c, input bit l);
        start = s; stop = p; clear = c; lap = l;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask
    initial begin
        model_reset();
        #1 compare();
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        // count and carries
        cycle(1, 0, 0, 0);
        repeat (71) cycle(0, 0, 0, 0);
        check("count_0110", 32'(disp1()), 32'h0110);
        // pause / resume keeps the partial second
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat (20) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        // saturation
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        repeat (3600) cycle(0, 0, 0, 0);
        repeat (10) cycle(1, 0, 0, 0);
        check("sat_disp", 32'(disp1()), 32'h5959);
        check("sat_ovf", 32'(b1.overflow), 32'd1);
        check("sat_run", 32'(b1.running), 32'd0);
        cycle(0, 0, 1, 0);
        check("clr_disp", 32'(disp1()), 32'h0000);
        check("clr_ovf", 32'(b1.overflow), 32'd0);
        // lap freeze
        cycle(1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        repeat (7) cycle(0, 0, 0, 0);
        check("lap_hold", 32'(disp1()), 32'h0006);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("lap_resume", 32'(disp1()), 32'h0015);
        // simultaneous commands
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        repeat (31) cycle(0, 0, 0, 0);
        cycle(1, 0, 1, 1);
        check("sim_run", 32'(b1.running), 32'd0);
        check("sim_disp", 32'(disp1()), 32'h0000);
        check("sim_lap", 32'(b1.lap_active), 32'd0);
        cycle(1, 1, 0, 0);
        check("idle_stopstart", 32'(b1.running), 32'd0);
        cycle(0, 0, 0, 1);
        check("idle_lap", 32'(b1.lap_active), 32'd0);
        // random traffic
        repeat (4000)
            cycle($urandom_range(99) < 15, $urandom_range(99) < 8,
                  $urandom_range(199) < 3, $urandom_range(99) < 6);
        // asynchronous reset mid-cycle
        cycle(1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        @(posedge clk);
        model_step();
        #2 rst = 1'b0;
        model_reset();
        #1 compare();
        check("arst_disp", 32'(disp1()), 32'h0000);
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
